// File: rtl/i2c_pkg.sv
// Shared I2C definitions: controller state encoding and the four quarter-period
// phase names of a bit slot. Intended for reuse by future I2C read/sequencer blocks.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT,
    ACK,
    STOP
  } i2c_state_t;

  localparam logic [1:0] PH0 = 2'd0;
  localparam logic [1:0] PH1 = 2'd1;
  localparam logic [1:0] PH2 = 2'd2;
  localparam logic [1:0] PH3 = 2'd3;

endpackage

// File: rtl/i2c_master_writer_if.sv
// Request/response handshake between the config sequencer and the I2C write master.
interface i2c_master_writer_if #(
  parameter int NUM_BYTES = 3
);

  logic                   i_start;
  logic [8*NUM_BYTES-1:0] i_data;
  logic                   o_busy;
  logic                   o_finished;
  logic                   o_nack;

  modport master (
    input  i_start,
    input  i_data,
    output o_busy,
    output o_finished,
    output o_nack
  );

  modport slave (
    output i_start,
    output i_data,
    input  o_busy,
    input  o_finished,
    input  o_nack
  );

endinterface

// File: rtl/i2c_tick_gen.sv
// SCL quarter-period tick generator: counts 0..CLK_DIV-1 while enabled and
// pulses o_tick on the terminal count; held at zero while disabled.
module i2c_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_tick
);

  localparam int               DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] LAST  = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_count;

  // NOTE: reset is synchronous, so it sits inside the clocked block like any other condition.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + DIV_W'(1);
    end
  end

  assign o_tick = i_en && (r_count == LAST);

endmodule

// File: rtl/i2c_master_writer.sv
// Write-only I2C master: START, NUM_BYTES bytes MSB-first each followed by an ACK
// slot, then STOP. Open-drain SDA, SCL paced by i2c_tick_gen quarter-period ticks.
module i2c_master_writer
  import i2c_pkg::*;
#(
  parameter int NUM_BYTES     = 3,
  parameter int CLK_DIV       = 4,
  parameter bit ABORT_ON_NACK = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  i2c_master_writer_if.master  bus,
  output logic                 o_scl,
  inout  wire                  o_sda
);

  localparam int                DATA_W    = 8 * NUM_BYTES;
  localparam int                BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);

  i2c_state_t        r_state;
  logic [1:0]        r_phase;
  logic [2:0]        r_bit;
  logic [BYTE_W-1:0] r_byte;
  logic [DATA_W-1:0] r_shift;
  logic              r_scl;
  logic              r_sda_oe;
  logic              r_busy;
  logic              r_finished;
  logic              r_nack;

  logic w_tick;
  logic w_sda_in;
  logic w_stop_next;

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (r_busy),
    .o_tick (w_tick)
  );

  assign w_sda_in    = o_sda;
  assign w_stop_next = (r_byte == LAST_BYTE) || (ABORT_ON_NACK && r_nack);

  // Each tick closes the current phase; the assignments below set up the next one.
  // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_phase    <= PH0;
      r_bit      <= '0;
      r_byte     <= '0;
      r_shift    <= '0;
      r_scl      <= 1'b1;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_finished <= 1'b0;
      r_nack     <= 1'b0;
    end else begin
      r_finished <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.i_start) begin
            r_state  <= START;
            r_phase  <= PH0;
            r_bit    <= '0;
            r_byte   <= '0;
            r_shift  <= bus.i_data;
            r_nack   <= 1'b0;
            r_busy   <= 1'b1;
            r_scl    <= 1'b1;
            r_sda_oe <= 1'b1;
          end
        end

        START: begin
          if (w_tick) begin
            if (r_phase == PH1) begin
              r_state  <= BIT;
              r_phase  <= PH0;
              r_scl    <= 1'b0;
              r_sda_oe <= ~r_shift[DATA_W-1];
              r_shift  <= {r_shift[DATA_W-2:0], 1'b0};
            end else begin
              r_phase <= r_phase + 2'd1;
            end
          end
        end

        BIT: begin
          if (w_tick) begin
            r_phase <= r_phase + 2'd1;
            case (r_phase)
              PH1: r_scl <= 1'b1;
              PH3: begin
                r_bit <= r_bit + 3'd1;
                r_scl <= 1'b0;
                if (r_bit == 3'd7) begin
                  r_state  <= ACK;
                  r_sda_oe <= 1'b0;
                end else begin
                  r_sda_oe <= ~r_shift[DATA_W-1];
                  r_shift  <= {r_shift[DATA_W-2:0], 1'b0};
                end
              end
              default: ;
            endcase
          end
        end

        ACK: begin
          if (w_tick) begin
            r_phase <= r_phase + 2'd1;
            case (r_phase)
              PH1: r_scl <= 1'b1;
              PH2: begin
                if (w_sda_in) r_nack <= 1'b1;
              end
              PH3: begin
                r_scl <= 1'b0;
                if (w_stop_next) begin
                  r_state  <= STOP;
                  r_byte   <= '0;
                  r_sda_oe <= 1'b1;
                end else begin
                  r_state  <= BIT;
                  r_byte   <= r_byte + BYTE_W'(1);
                  r_sda_oe <= ~r_shift[DATA_W-1];
                  r_shift  <= {r_shift[DATA_W-2:0], 1'b0};
                end
              end
              default: ;
            endcase
          end
        end

        STOP: begin
          if (w_tick) begin
            r_phase <= r_phase + 2'd1;
            case (r_phase)
              PH1: r_scl    <= 1'b1;
              PH2: r_sda_oe <= 1'b0;
              PH3: begin
                r_state    <= IDLE;
                r_busy     <= 1'b0;
                r_finished <= 1'b1;
              end
              default: ;
            endcase
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_scl          = r_scl;
  assign o_sda          = r_sda_oe ? 1'b0 : 1'bz;
  assign bus.o_busy     = r_busy;
  assign bus.o_finished = r_finished;
  assign bus.o_nack     = r_nack;

endmodule

// File: tb/tb_i2c_master_writer.sv
// Directed bench for i2c_master_writer: three parameterisations, each with a
// pulled-up SDA, a behavioural ACKing slave and a START/STOP/byte decoder.
module tb_i2c_master_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  i2c_master_writer_if #(.NUM_BYTES(3)) bus_a ();
  i2c_master_writer_if #(.NUM_BYTES(3)) bus_b ();
  i2c_master_writer_if #(.NUM_BYTES(2)) bus_c ();

  logic scl0, scl1, scl2;
  tri1  sda0, sda1, sda2;
  logic [2:0] slave_pull = '0;

  assign sda0 = slave_pull[0] ? 1'b0 : 1'bz;
  assign sda1 = slave_pull[1] ? 1'b0 : 1'bz;
  assign sda2 = slave_pull[2] ? 1'b0 : 1'bz;

  i2c_master_writer #(.NUM_BYTES(3), .CLK_DIV(4), .ABORT_ON_NACK(1'b1)) dut_a (
    .i_clk(clk), .i_rst(rst), .bus(bus_a), .o_scl(scl0), .o_sda(sda0));
  i2c_master_writer #(.NUM_BYTES(3), .CLK_DIV(4), .ABORT_ON_NACK(1'b0)) dut_b (
    .i_clk(clk), .i_rst(rst), .bus(bus_b), .o_scl(scl1), .o_sda(sda1));
  i2c_master_writer #(.NUM_BYTES(2), .CLK_DIV(1), .ABORT_ON_NACK(1'b1)) dut_c (
    .i_clk(clk), .i_rst(rst), .bus(bus_c), .o_scl(scl2), .o_sda(sda2));

  wire [2:0] scl_v = {scl2, scl1, scl0};
  wire [2:0] sda_v = {sda2, sda1, sda0};

  // Bus monitor and slave, sampled on the falling clock edge away from DUT updates.
  logic [2:0] prev_scl = '1;
  logic [2:0] prev_sda = '1;
  int         bitc   [3];
  int         nbytes [3];
  int         starts [3];
  int         stops  [3];
  logic [7:0] sh     [3];
  logic [7:0] got    [3][4];
  bit         nack_plan [3][4];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        slave_pull[i] = 1'b0;
        bitc[i]       = 0;
      end else begin
        if (scl_v[i] === 1'b1 && prev_scl[i] === 1'b1 && sda_v[i] !== prev_sda[i]) begin
          if (sda_v[i] === 1'b0) begin
            starts[i]++;
            bitc[i]   = 0;
            nbytes[i] = 0;
          end else if (sda_v[i] === 1'b1) begin
            stops[i]++;
          end
        end
        if (scl_v[i] === 1'b1 && prev_scl[i] === 1'b0) begin
          if (bitc[i] < 8) sh[i] = {sh[i][6:0], sda_v[i]};
          bitc[i]++;
          if (bitc[i] == 8 && nbytes[i] < 4) begin
            got[i][nbytes[i]] = sh[i];
            nbytes[i]++;
          end
        end
        if (scl_v[i] === 1'b0 && prev_scl[i] === 1'b1) begin
          if (bitc[i] == 8 && nbytes[i] >= 1) begin
            slave_pull[i] = !nack_plan[i][nbytes[i]-1];
          end else if (bitc[i] == 9) begin
            slave_pull[i] = 1'b0;
            bitc[i]       = 0;
          end
        end
      end
      prev_scl[i] = scl_v[i];
      prev_sda[i] = sda_v[i];
    end
  end

  function automatic logic get_fin(input int idx);
    case (idx)
      0:       return bus_a.o_finished;
      1:       return bus_b.o_finished;
      default: return bus_c.o_finished;
    endcase
  endfunction

  function automatic logic get_busy(input int idx);
    case (idx)
      0:       return bus_a.o_busy;
      1:       return bus_b.o_busy;
      default: return bus_c.o_busy;
    endcase
  endfunction

  function automatic logic get_nack(input int idx);
    case (idx)
      0:       return bus_a.o_nack;
      1:       return bus_b.o_nack;
      default: return bus_c.o_nack;
    endcase
  endfunction

  task automatic drive(input int idx, input logic start, input logic [23:0] data);
    case (idx)
      0:       begin bus_a.i_start = start; bus_a.i_data = data;       end
      1:       begin bus_b.i_start = start; bus_b.i_data = data;       end
      default: begin bus_c.i_start = start; bus_c.i_data = data[15:0]; end
    endcase
  endtask

  // One request accepted at edge E, then a fixed observation window measured from E.
  task automatic run(input int idx, input logic [23:0] data, input int inject_at,
                     input int window, output int lat, output int fins,
                     output int dstart, output int dstop, output logic busy1,
                     output logic nack1);
    int s0, p0;
    s0   = starts[idx];
    p0   = stops[idx];
    lat  = -1;
    fins = 0;
    drive(idx, 1'b1, data);
    @(posedge clk); #1;
    drive(idx, 1'b0, data);
    for (int n = 1; n <= window; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        busy1 = get_busy(idx);
        nack1 = get_nack(idx);
      end
      if (get_fin(idx)) begin
        fins++;
        if (lat < 0) lat = n;
      end
      if (inject_at > 0 && n == inject_at)     drive(idx, 1'b1, 24'hFFFFFF);
      if (inject_at > 0 && n == inject_at + 1) drive(idx, 1'b0, 24'hFFFFFF);
    end
    dstart = starts[idx] - s0;
    dstop  = stops[idx] - p0;
  endtask

  task automatic test_reset();
    drive(0, 1'b0, 24'h0); drive(1, 1'b0, 24'h0); drive(2, 1'b0, 24'h0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    total++; if (scl0 !== 1'b1)     begin bad++; $display("FAIL reset_scl: got %b want 1", scl0); end
    total++; if (sda0 !== 1'b1)     begin bad++; $display("FAIL reset_sda: got %b want 1 (released)", sda0); end
    total++; if (get_busy(0) !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", get_busy(0)); end
    total++; if (get_fin(0) !== 1'b0)  begin bad++; $display("FAIL reset_fin: got %b want 0", get_fin(0)); end
    total++; if (get_nack(0) !== 1'b0) begin bad++; $display("FAIL reset_nack: got %b want 0", get_nack(0)); end
    total++; if (scl2 !== 1'b1)     begin bad++; $display("FAIL reset_scl_c: got %b want 1", scl2); end
  endtask

  task automatic test_full_frame();
    int lat, fins, ds, dp; logic b1, n1;
    logic [7:0] exp_b [3] = '{8'h34, 8'h1E, 8'h00};
    run(0, 24'h341E00, 0, 600, lat, fins, ds, dp, b1, n1);
    total++; if (b1 !== 1'b1)   begin bad++; $display("FAIL full_busy_e1: got %b want 1", b1); end
    total++; if (lat != 456)    begin bad++; $display("FAIL full_latency: got %0d want 456", lat); end
    total++; if (fins != 1)     begin bad++; $display("FAIL full_fin_pulses: got %0d want 1", fins); end
    total++; if (nbytes[0] != 3) begin bad++; $display("FAIL full_nbytes: got %0d want 3", nbytes[0]); end
    for (int k = 0; k < 3; k++) begin
      total++; if (got[0][k] !== exp_b[k]) begin bad++; $display("FAIL full_byte%0d: got %h want %h", k, got[0][k], exp_b[k]); end
    end
    total++; if (get_nack(0) !== 1'b0) begin bad++; $display("FAIL full_nack: got %b want 0", get_nack(0)); end
    total++; if (ds != 1 || dp != 1) begin bad++; $display("FAIL full_start_stop: got %0d/%0d want 1/1", ds, dp); end
  endtask

  task automatic test_abort();
    int lat, fins, ds, dp; logic b1, n1;
    nack_plan[0][0] = 1'b1;
    run(0, 24'hA55A3C, 0, 600, lat, fins, ds, dp, b1, n1);
    nack_plan[0][0] = 1'b0;
    total++; if (lat != 168)     begin bad++; $display("FAIL abort_latency: got %0d want 168", lat); end
    total++; if (nbytes[0] != 1) begin bad++; $display("FAIL abort_nbytes: got %0d want 1", nbytes[0]); end
    total++; if (got[0][0] !== 8'hA5) begin bad++; $display("FAIL abort_byte0: got %h want a5", got[0][0]); end
    total++; if (get_nack(0) !== 1'b1) begin bad++; $display("FAIL abort_nack: got %b want 1", get_nack(0)); end
    total++; if (ds != 1 || dp != 1) begin bad++; $display("FAIL abort_start_stop: got %0d/%0d want 1/1", ds, dp); end
  endtask

  task automatic test_no_abort();
    int lat, fins, ds, dp; logic b1, n1;
    logic [7:0] exp_b [3] = '{8'h0F, 8'hF0, 8'h81};
    nack_plan[1][1] = 1'b1;
    run(1, 24'h0FF081, 0, 600, lat, fins, ds, dp, b1, n1);
    nack_plan[1][1] = 1'b0;
    total++; if (lat != 456)     begin bad++; $display("FAIL noabort_latency: got %0d want 456", lat); end
    total++; if (nbytes[1] != 3) begin bad++; $display("FAIL noabort_nbytes: got %0d want 3", nbytes[1]); end
    for (int k = 0; k < 3; k++) begin
      total++; if (got[1][k] !== exp_b[k]) begin bad++; $display("FAIL noabort_byte%0d: got %h want %h", k, got[1][k], exp_b[k]); end
    end
    repeat (5) @(posedge clk); #1;
    total++; if (get_nack(1) !== 1'b1) begin bad++; $display("FAIL noabort_nack_sticky: got %b want 1", get_nack(1)); end
    run(1, 24'h55AA33, 0, 600, lat, fins, ds, dp, b1, n1);
    total++; if (n1 !== 1'b0)  begin bad++; $display("FAIL noabort_nack_clear: got %b want 0", n1); end
    total++; if (lat != 456)   begin bad++; $display("FAIL noabort_rerun_latency: got %0d want 456", lat); end
    total++; if (get_nack(1) !== 1'b0) begin bad++; $display("FAIL noabort_rerun_nack: got %b want 0", get_nack(1)); end
  endtask

  task automatic test_ignore_start();
    int lat, fins, ds, dp; logic b1, n1;
    logic [7:0] exp_b [3] = '{8'hC3, 8'h5A, 8'h96};
    run(0, 24'hC35A96, 100, 600, lat, fins, ds, dp, b1, n1);
    total++; if (lat != 456)  begin bad++; $display("FAIL ignore_latency: got %0d want 456", lat); end
    total++; if (fins != 1)   begin bad++; $display("FAIL ignore_fin_pulses: got %0d want 1", fins); end
    for (int k = 0; k < 3; k++) begin
      total++; if (got[0][k] !== exp_b[k]) begin bad++; $display("FAIL ignore_byte%0d: got %h want %h", k, got[0][k], exp_b[k]); end
    end
    total++; if (ds != 1 || dp != 1) begin bad++; $display("FAIL ignore_start_stop: got %0d/%0d want 1/1", ds, dp); end
  endtask

  task automatic test_reset_mid();
    int lat, fins, ds, dp; logic b1, n1;
    logic [7:0] exp_b [3] = '{8'hDE, 8'hAD, 8'h42};
    drive(0, 1'b1, 24'h123456);
    @(posedge clk); #1;
    drive(0, 1'b0, 24'h123456);
    repeat (200) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (scl0 !== 1'b1)        begin bad++; $display("FAIL midrst_scl: got %b want 1", scl0); end
    total++; if (sda0 !== 1'b1)        begin bad++; $display("FAIL midrst_sda: got %b want 1 (released)", sda0); end
    total++; if (get_busy(0) !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", get_busy(0)); end
    @(posedge clk); #1;
    run(0, 24'hDEAD42, 0, 600, lat, fins, ds, dp, b1, n1);
    total++; if (lat != 456) begin bad++; $display("FAIL midrst_rerun_latency: got %0d want 456", lat); end
    for (int k = 0; k < 3; k++) begin
      total++; if (got[0][k] !== exp_b[k]) begin bad++; $display("FAIL midrst_byte%0d: got %h want %h", k, got[0][k], exp_b[k]); end
    end
  endtask

  task automatic test_small_fast();
    int lat, fins, ds, dp; logic b1, n1;
    run(2, 24'h00B72D, 0, 150, lat, fins, ds, dp, b1, n1);
    total++; if (lat != 78)       begin bad++; $display("FAIL small_latency: got %0d want 78", lat); end
    total++; if (nbytes[2] != 2)  begin bad++; $display("FAIL small_nbytes: got %0d want 2", nbytes[2]); end
    total++; if (got[2][0] !== 8'hB7) begin bad++; $display("FAIL small_byte0: got %h want b7", got[2][0]); end
    total++; if (got[2][1] !== 8'h2D) begin bad++; $display("FAIL small_byte1: got %h want 2d", got[2][1]); end
    total++; if (get_nack(2) !== 1'b0) begin bad++; $display("FAIL small_nack: got %b want 0", get_nack(2)); end
    total++; if (ds != 1 || dp != 1) begin bad++; $display("FAIL small_start_stop: got %0d/%0d want 1/1", ds, dp); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_abort();
    test_no_abort();
    test_ignore_start();
    test_reset_mid();
    test_small_fast();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
